// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the LFSR sequencer.
//   - lfsr_state_e : controller FSM states (IDLE/LOAD/RUN/DONE)
//   - *_DEFAULT    : default LFSR geometry (3-bit, taps 3'b011, seed 3'b001)
//   - lfsr_next()  : one Fibonacci step, next = {fb, s[w-1:1]}, fb = ^(s & taps)
package lfsr_pkg;

  // Widest LFSR the step function supports; callers zero-extend into this.
  localparam int LFSR_MAX_W = 32;

  localparam int                         WIDTH_DEFAULT = 3;
  localparam logic [WIDTH_DEFAULT-1:0]   TAPS_DEFAULT  = 3'b011;
  localparam logic [WIDTH_DEFAULT-1:0]   SEED_DEFAULT_VAL = 3'b001;
  localparam int                         CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } lfsr_state_e;

  // s and taps must be zero above bit w-1. The shift pulls a zero into
  // bit w-1, which is then replaced by the feedback bit.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    w
  );
    logic [LFSR_MAX_W-1:0] r;
    logic                  fb;
    fb = ^(s & taps);
    r  = s >> 1;
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i == w - 1) r[i] = fb;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: WIDTH-bit Fibonacci LFSR register.
//   clk, rst      : clock, synchronous active-high reset (state <= SEED_DEFAULT)
//   load/load_val : synchronous load, wins over adv
//   adv           : advance one step
//   state         : current register value
//   next_state    : value the register takes on adv (combinational)
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_DEFAULT,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = SEED_DEFAULT_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adv,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  logic [LFSR_MAX_W-1:0] nxt_w;

  assign nxt_w      = lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), WIDTH);
  assign next_state = nxt_w[WIDTH-1:0];

  // Upper bits of the wide step result are always zero.
  generate
    if (WIDTH < LFSR_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^nxt_w[LFSR_MAX_W-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)       state <= SEED_DEFAULT;
    else if (load) state <= load_val;
    else if (adv)  state <= next_state;
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: burst sequencer around an LFSR pseudo-random source.
//   clk, rst        : clock, synchronous active-high reset
//   seed_wr/seed_in : load a new nonzero seed (IDLE only); zero pulses seed_err
//   start/len       : run a burst of len words (IDLE only)
//   stop            : abort the burst in LOAD or RUN
//   out_valid/out_ready/out_data : word stream, one word per cycle max
//   busy            : LOAD or RUN
//   done            : one-cycle pulse as a burst ends (normally or by stop)
//   seed_err        : one-cycle pulse after a rejected zero seed
//   period_wrap     : one-cycle pulse after the LFSR steps back to the seed
// Optional (macro LFSR_CTRL_STATS_EN):
//   word_total      : saturating count of all transfers since reset
//   burst_aborted   : sticky, set by stop in LOAD/RUN, cleared by next start
module lfsr_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_DEFAULT,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = SEED_DEFAULT_VAL,
  parameter int               CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_wr,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             stop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             seed_err,
  output logic             period_wrap
`ifdef LFSR_CTRL_STATS_EN
  ,
  output logic [31:0]      word_total,
  output logic             burst_aborted
`endif
);

  lfsr_state_e      st;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             xfer;
  logic             last_word;
  logic             core_load;

  assign xfer      = out_valid & out_ready;
  assign cnt_inc   = cnt + 1'b1;
  assign last_word = xfer && (cnt_inc == len_q);
  assign core_load = (st == ST_LOAD);
  assign out_data  = lfsr_q;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (core_load),
    .load_val   (seed_q),
    .adv        (xfer),
    .state      (lfsr_q),
    .next_state (lfsr_nxt)
  );

  // Status outputs are flopped and updated on the same transition that
  // moves st, so they never glitch on a state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_IDLE;
      seed_q      <= SEED_DEFAULT;
      len_q       <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      seed_err    <= 1'b0;
      period_wrap <= 1'b0;
    end else begin
      done        <= 1'b0;
      seed_err    <= 1'b0;
      period_wrap <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          // Seed write lands before a same-cycle start, so LOAD sees it.
          if (seed_wr) begin
            if (seed_in != '0) seed_q   <= seed_in;
            else               seed_err <= 1'b1;
          end
          if (start) begin
            len_q <= len;
            busy  <= 1'b1;
            st    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt <= '0;
          if (stop || len_q == '0) begin
            busy <= 1'b0;
            done <= 1'b1;
            st   <= ST_DONE;
          end else begin
            out_valid <= 1'b1;
            st        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            cnt <= cnt_inc;
            if (lfsr_nxt == seed_q) period_wrap <= 1'b1;
          end
          // A transfer coinciding with stop has already been counted above.
          if (stop || last_word) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            st        <= ST_DONE;
          end
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

`ifdef LFSR_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      word_total    <= '0;
      burst_aborted <= 1'b0;
    end else begin
      if (xfer && word_total != 32'hFFFF_FFFF) word_total <= word_total + 32'd1;
      if (st == ST_IDLE && start)
        burst_aborted <= 1'b0;
      else if (stop && (st == ST_LOAD || st == ST_RUN))
        burst_aborted <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Bench for lfsr_ctrl: directed bursts followed by random bursts. Expected
// words come from the known period-7 sequence table; a negedge monitor pops
// and compares each transfer and tallies done/wrap/seed_err pulses.
module tb_lfsr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_wr;
  logic [2:0] seed_in;
  logic       start;
  logic [7:0] len;
  logic       stop;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_data;
  logic       busy;
  logic       done;
  logic       seed_err;
  logic       period_wrap;
`ifdef LFSR_CTRL_STATS_EN
  logic [31:0] word_total;
  logic        burst_aborted;
`endif

  lfsr_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .seed_wr     (seed_wr),
    .seed_in     (seed_in),
    .start       (start),
    .len         (len),
    .stop        (stop),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .seed_err    (seed_err),
    .period_wrap (period_wrap)
`ifdef LFSR_CTRL_STATS_EN
    ,
    .word_total    (word_total),
    .burst_aborted (burst_aborted)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default LFSR cycle as listed for taps 3'b011.
  int seq[7] = '{1, 4, 2, 5, 6, 7, 3};
  int exp_q[$];

  int  model_seed  = 1;
  longint model_total = 0;
  int  model_abort = 0;

  int cyc = 0, burst_x = 0, last_x = -10, valid_n = 0;
  int done_n = 0, wrap_n = 0, err_n = 0;
  bit prev_stall = 0;
  logic [2:0] prev_data;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input int s);
    for (int i = 0; i < 7; i++) if (seq[i] == s) return i;
    return 0;
  endfunction

  // Monitor
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (done && burst_x > 0) chk("done_latency", cyc - last_x, 1);
      if (done) done_n++;
      if (period_wrap) begin
        wrap_n++;
        chk("wrap_position", (burst_x > 0 && burst_x % 7 == 0 && last_x == cyc - 1), 1);
      end
      if (seed_err) err_n++;
      if (out_valid) valid_n++;
      if (prev_stall && out_valid) chk("stall_hold", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0d expected none (cycle %0d)", out_data, cyc);
        end else begin
          chk("word", out_data, exp_q.pop_front());
        end
        burst_x++;
        last_x = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic seed_write(input int v);
    int e0;
    e0 = err_n;
    seed_wr = 1'b1; seed_in = 3'(v);
    @(posedge clk); #1;
    seed_wr = 1'b0;
    @(posedge clk); #1;
    chk("seed_err_pulse", err_n - e0, (v == 0) ? 1 : 0);
    if (v != 0) model_seed = v;
  endtask

  // pct < 0 selects the fixed ready pattern 1,0,0,1,1 then 1.
  task automatic burst(input int n, input int stop_after, input int pct, input bit wr_mid);
    int i0, nw, d0, w0, e0;
    int tog[5] = '{1, 0, 0, 1, 1};
    nw = (stop_after > 0) ? stop_after : n;
    i0 = idx_of(model_seed);
    for (int k = 0; k < nw; k++) exp_q.push_back(seq[(i0 + k) % 7]);
    d0 = done_n; w0 = wrap_n; e0 = err_n;
    burst_x = 0; valid_n = 0;
    start = 1'b1; len = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_in_load", busy, 1);
    chk("valid_in_load", out_valid, 0);
    for (int c = 0; c < 1000 && done_n == d0; c++) begin
      stop = 1'b0; seed_wr = 1'b0;
      if (pct < 0) out_ready = (c < 5) ? 1'(tog[c]) : 1'b1;
      else         out_ready = ($urandom_range(99) < pct);
      if (stop_after > 0 && burst_x == stop_after - 1 && out_valid) begin
        out_ready = 1'b1; stop = 1'b1;
      end
      if (wr_mid && c == 2) begin seed_wr = 1'b1; seed_in = 3'b010; end
      @(posedge clk); #1;
      if (c == 0) begin
        chk("first_valid_latency", out_valid, (n > 0) ? 1 : 0);
        chk("busy_after_load", busy, (n > 0) ? 1 : 0);
      end
    end
    stop = 1'b0; seed_wr = 1'b0;
    if (done_n == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 1000 cycles");
      exp_q.delete();
    end
    chk("done_count", done_n - d0, 1);
    chk("wrap_count", wrap_n - w0, nw / 7);
    chk("no_seed_err_in_burst", err_n - e0, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_after_done", busy, 0);
    if (n == 0) chk("no_valid_len0", valid_n, 0);
    model_total += nw;
    model_abort = (stop_after > 0) ? 1 : 0;
`ifdef LFSR_CTRL_STATS_EN
    chk("word_total", word_total, model_total);
    chk("burst_aborted", burst_aborted, model_abort);
`endif
  endtask

  initial begin
    int d0, n, sa;
    rst = 1'b1; seed_wr = 1'b0; seed_in = '0; start = 1'b0;
    len = '0; stop = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seed_err", seed_err, 0);
    chk("rst_wrap", period_wrap, 0);
    chk("rst_data", out_data, 1);
`ifdef LFSR_CTRL_STATS_EN
    chk("rst_word_total", word_total, 0);
    chk("rst_aborted", burst_aborted, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Full period with out_ready held high.
    burst(7, 0, 100, 0);
    // New seed and a stalling consumer.
    seed_write(5);
    burst(3, 0, -1, 0);
    // Zero seed rejected; write during RUN ignored.
    seed_write(0);
    burst(10, 0, 80, 1);
    // Zero length.
    burst(0, 0, 100, 0);
    // Stop with the 4th transfer.
    burst(20, 4, 100, 0);
    // Long burst wrapping several periods.
    burst(22, 0, 100, 0);

    // Reset in the middle of RUN.
    exp_q.delete();
    for (int k = 0; k < 20; k++) exp_q.push_back(seq[(idx_of(model_seed) + k) % 7]);
    start = 1'b1; len = 8'd20; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    d0 = done_n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_n - d0, 0);
    exp_q.delete();
    model_seed = 1; model_total = 0; model_abort = 0;
    burst(8, 0, 100, 0);

    // Random bursts.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(2) == 0) seed_write($urandom_range(0, 7));
      n  = $urandom_range(0, 20);
      sa = (n > 0 && $urandom_range(3) == 0) ? $urandom_range(1, n) : 0;
      burst(n, sa, $urandom_range(40, 100), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
